// File: rtl/l2_tag_ctrl_pkg.sv
// Shared definitions for the L2 tag controller: address split, FSM states,
// tree-PLRU bit meanings and small address helpers.
package l2_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 9;
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORD_W   = TAG_W + 1;
    localparam int NUM_WAYS = 4;

    // Tree PLRU: the root bit picks a half, a leaf bit picks a way within it.
    localparam int PLRU_ROOT  = 0;  // 1 = victim in ways 2/3, 0 = ways 0/1
    localparam int PLRU_LEFT  = 1;  // 1 = way 1, 0 = way 0
    localparam int PLRU_RIGHT = 2;  // 1 = way 3, 0 = way 2

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_COMPARE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_REFILL    = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_RESP      = 3'd6
    } l2_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W+INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/l2_tag_ctrl_if.sv
// Bundle of the request/response, tag RAM and memory handshake signals.
// Handshakes: a request transfers on the cycle req_valid & req_ready are both
// high; mem_wb_req / mem_rd_req stay high until a one-cycle mem_ack is seen;
// the tag RAM write strobe stays high until l2_complete is sampled high.
interface l2_tag_ctrl_if;
    import l2_pkg::*;

    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_W-1:0]            req_addr;
    logic                         req_we;
    logic                         resp_valid;
    logic                         resp_hit;
    logic [1:0]                   resp_way;
    logic [NUM_WAYS-1:0]          l2_block_re;
    logic [NUM_WAYS-1:0]          l2_block_we;
    logic [INDEX_W-1:0]           l2_index;
    logic [WORD_W-1:0]            l2_tag_wd;
    logic                         l2_dirty_wd;
    logic [NUM_WAYS*WORD_W-1:0]   l2_tag_rd;
    logic [NUM_WAYS-1:0]          l2_dirty_rd;
    logic [2:0]                   plru;
    logic                         l2_complete;
    logic                         mem_wb_req;
    logic [ADDR_W-1:0]            mem_wb_addr;
    logic                         mem_rd_req;
    logic [ADDR_W-1:0]            mem_rd_addr;
    logic                         mem_ack;

    modport master (
        output req_valid, req_addr, req_we, l2_tag_rd, l2_dirty_rd, plru,
               l2_complete, mem_ack,
        input  req_ready, resp_valid, resp_hit, resp_way, l2_block_re,
               l2_block_we, l2_index, l2_tag_wd, l2_dirty_wd, mem_wb_req,
               mem_wb_addr, mem_rd_req, mem_rd_addr
    );

    modport slave (
        input  req_valid, req_addr, req_we, l2_tag_rd, l2_dirty_rd, plru,
               l2_complete, mem_ack,
        output req_ready, resp_valid, resp_hit, resp_way, l2_block_re,
               l2_block_we, l2_index, l2_tag_wd, l2_dirty_wd, mem_wb_req,
               mem_wb_addr, mem_rd_req, mem_rd_addr
    );

endinterface

// File: rtl/l2_tag_ctrl_victim_sel.sv
// Victim way choice: lowest invalid way if any, otherwise follow the PLRU tree.
module l2_victim_sel
    import l2_pkg::*;
(
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [2:0]          plru,
    output logic [1:0]          way
);

    // Invalid ways win in ascending order; a full set falls back to the tree.
    always_comb begin
        way = 2'd0;
        if (!valid[0])      way = 2'd0;
        else if (!valid[1]) way = 2'd1;
        else if (!valid[2]) way = 2'd2;
        else if (!valid[3]) way = 2'd3;
        else if (plru[PLRU_ROOT]) way = plru[PLRU_RIGHT] ? 2'd3 : 2'd2;
        else                      way = plru[PLRU_LEFT]  ? 2'd1 : 2'd0;
    end

endmodule

// File: rtl/l2_tag_ctrl.sv
// L2 tag lookup / replacement controller: reads all four ways, compares tags,
// picks a victim, runs write-back and refill handshakes, then writes the tag.
module l2_tag_ctrl
    import l2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    l2_tag_ctrl_if.slave bus,
    output l2_state_t   dbg_state
);

    l2_state_t state, state_next;

    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] index_q;
    logic               we_q;
    logic               hit_q;
    logic [1:0]         way_q;
    logic [TAG_W-1:0]   vic_tag_q;
    logic               dirty_q;

    logic [WORD_W-1:0]   way_word [NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_vec;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                any_hit;
    logic [1:0]          hit_way;
    logic [1:0]          vic_way;
    logic [1:0]          sel_way;
    logic                vic_valid;

    assign dbg_state = state;

    // Split read data per way and find the lowest-numbered tag hit.
    always_comb begin
        hit_vec   = '0;
        valid_vec = '0;
        hit_way   = 2'd0;
        for (int n = 0; n < NUM_WAYS; n++) begin
            way_word[n]  = bus.l2_tag_rd[n*WORD_W +: WORD_W];
            valid_vec[n] = way_word[n][TAG_W];
            hit_vec[n]   = way_word[n][TAG_W] & (way_word[n][TAG_W-1:0] == req_tag_q);
        end
        for (int n = NUM_WAYS - 1; n >= 0; n--) begin
            if (hit_vec[n]) hit_way = 2'(n);
        end
        any_hit = |hit_vec;
    end

    l2_victim_sel u_victim_sel (
        .valid (valid_vec),
        .plru  (bus.plru),
        .way   (vic_way)
    );

    assign sel_way   = any_hit ? hit_way : vic_way;
    assign vic_valid = valid_vec[vic_way];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Captured request and the way/tag/dirty decided during compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_tag_q <= '0;
            index_q   <= '0;
            we_q      <= 1'b0;
            hit_q     <= 1'b0;
            way_q     <= 2'd0;
            vic_tag_q <= '0;
            dirty_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                req_tag_q <= addr_tag(bus.req_addr);
                index_q   <= addr_index(bus.req_addr);
                we_q      <= bus.req_we;
            end
            if (state == ST_COMPARE) begin
                hit_q     <= any_hit;
                way_q     <= sel_way;
                vic_tag_q <= way_word[sel_way][TAG_W-1:0];
                dirty_q   <= bus.l2_dirty_rd[sel_way];
            end
        end
    end

    // Next state and all outputs; everything idles low except req_ready.
    always_comb begin
        state_next      = state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_hit    = 1'b0;
        bus.resp_way    = 2'd0;
        bus.l2_block_re = '0;
        bus.l2_block_we = '0;
        bus.l2_index    = '0;
        bus.l2_tag_wd   = '0;
        bus.l2_dirty_wd = 1'b0;
        bus.mem_wb_req  = 1'b0;
        bus.mem_wb_addr = '0;
        bus.mem_rd_req  = 1'b0;
        bus.mem_rd_addr = '0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                bus.l2_block_re = '1;
                bus.l2_index    = index_q;
                state_next      = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (any_hit)
                    state_next = ST_UPDATE;
                else if (vic_valid && bus.l2_dirty_rd[vic_way])
                    state_next = ST_WRITEBACK;
                else
                    state_next = ST_REFILL;
            end
            ST_WRITEBACK: begin
                bus.mem_wb_req  = 1'b1;
                bus.mem_wb_addr = {vic_tag_q, index_q, {OFFSET_W{1'b0}}};
                if (bus.mem_ack) state_next = ST_REFILL;
            end
            ST_REFILL: begin
                bus.mem_rd_req  = 1'b1;
                bus.mem_rd_addr = {req_tag_q, index_q, {OFFSET_W{1'b0}}};
                if (bus.mem_ack) state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                bus.l2_block_we = 4'b0001 << way_q;
                bus.l2_index    = index_q;
                bus.l2_tag_wd   = {1'b1, req_tag_q};
                bus.l2_dirty_wd = we_q | (hit_q & dirty_q);
                if (bus.l2_complete) state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit_q;
                bus.resp_way   = way_q;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/l2_tag_ctrl.md
Name: l2_tag_ctrl

Overview:
Lookup/replacement controller sitting directly upstream of the L2 tag RAM.
- Accepts one L2 request at a time.
- Drives the tag RAM's per-way read/write strobes, index, tag and dirty write data.
- Compares the four returned tags, chooses a victim (invalid way first, otherwise 3-bit tree PLRU), and sequences the dirty write-back and refill handshakes with memory.
- Updates the tag/dirty/PLRU fields and reports hit or miss plus the selected way to the L2 data path.

Parameters:
ADDR_W, 32, request address width
OFFSET_W, 6, line offset bits (64-byte line)
INDEX_W, 9, set index bits (512 sets)
TAG_W, 17, stored tag bits; tag RAM word = {valid, tag} = TAG_W+1 = 18

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request strobe
req_ready  out  1  controller idle, request accepted when valid&ready
req_addr  in  ADDR_W  request address
req_we  in  1  1=write request (marks line dirty)
resp_valid  out  1  one-cycle response pulse
resp_hit  out  1  1=hit, 0=miss (refilled)
resp_way  out  2  way holding the line
l2_block_re  out  4  per-way tag RAM read strobes, bit n = way n
l2_block_we  out  4  per-way tag RAM write strobes, one-hot or zero
l2_index  out  INDEX_W  set index
l2_tag_wd  out  TAG_W+1  {valid, tag} write data
l2_dirty_wd  out  1  dirty write data
l2_tag_rd  in  4*(TAG_W+1)  way3..way0 tag read data
l2_dirty_rd  in  4  way3..way0 dirty bits
plru  in  3  PLRU field read data
l2_complete  in  1  tag RAM write-complete pulse
mem_wb_req  out  1  write-back request, held until mem_ack
mem_wb_addr  out  ADDR_W  {victim tag, index, 0}
mem_rd_req  out  1  refill request, held until mem_ack
mem_rd_addr  out  ADDR_W  {req tag, index, 0}
mem_ack  in  1  memory handshake acknowledge, one cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - req_ready=1.
  - All other outputs 0.
  - Captured request registers cleared.
  - Takes effect mid-operation with no completion pulse.
- Address split: tag=addr[ADDR_W-1:OFFSET_W+INDEX_W], index=addr[OFFSET_W+INDEX_W-1:OFFSET_W].
- IDLE:
  - req_ready=1.
  - On valid&ready: capture addr and we, then go to LOOKUP.
- LOOKUP (1 cycle):
  - l2_block_re=4'b1111 and l2_index driven.
  - RAM read latency is 1 cycle, so go to COMPARE.
- COMPARE:
  - hit[n] = tag_rd[n][TAG_W] & (tag_rd[n][TAG_W-1:0]==req_tag).
  - Multiple hits are illegal; the lowest way wins.
  - Hit: way=hit way, go to UPDATE.
  - Miss: victim = lowest invalid way. If all ways are valid:
    - plru[0]=1 → plru[2]?3:2
    - plru[0]=0 → plru[1]?1:0
  - Victim valid and dirty → WRITEBACK, else → REFILL.
  - Victim tag and dirty bit are latched here.
- WRITEBACK:
  - mem_wb_req=1 with mem_wb_addr until mem_ack.
  - On mem_ack go to REFILL.
- REFILL:
  - mem_rd_req=1 with mem_rd_addr until mem_ack.
  - On mem_ack go to UPDATE.
- UPDATE:
  - l2_block_we[way]=1, l2_tag_wd={1'b1,req_tag}.
  - l2_dirty_wd = req_we | (hit & latched dirty of hit way).
  - Held until l2_complete=1 is sampled, then go to RESP.
  - The PLRU write is performed by the tag RAM from the strobe.
- RESP (1 cycle):
  - resp_valid=1 with resp_hit and resp_way.
  - Then IDLE, with req_ready=1 the next cycle.
- Only one strobe set is active at any time; re and we are never asserted together.
- req_valid while busy is ignored (req_ready=0).
- mem_ack outside WRITEBACK/REFILL is ignored.
- Latency:
  - Hit: LOOKUP, COMPARE, UPDATE (≥2 cycles awaiting l2_complete), RESP.
  - Miss: adds the memory handshakes.

Decomposition:
- Shared package l2_pkg:
  - State encoding (IDLE, LOOKUP, COMPARE, WRITEBACK, REFILL, UPDATE, RESP).
  - Address-field widths.
  - PLRU bit meanings.
- One natural sub-module: l2_victim_sel. It is combinational: valid[3:0] and plru[2:0] in, way[1:0] out, implementing the invalid-first/tree-PLRU rule.

Test Plan:
- Empty set, read 0x0001_2340 → LOOKUP re=1111, no wb, mem_rd_req addr 0x0001_2340, UPDATE we=0001 tag_wd={1,0x00002} dirty_wd=0, resp_hit=0 way=0.
- Repeat the same address as a write → no mem traffic, we=0001, dirty_wd=1, resp_hit=1 way=0.
- All ways valid and clean, plru=3'b101 → victim way3, only mem_rd_req, we=1000.
- All ways valid, plru=3'b010, way1 dirty tag 0x1ABCD → mem_wb_req addr {0x1ABCD,index,6'b0} before mem_rd_req, resp way=1 hit=0.
- Hold l2_complete low 5 cycles in UPDATE → we held steady, no resp_valid until the cycle after complete; req_valid pulses in between are not accepted.
- Assert rst low during REFILL → all outputs 0 immediately and req_ready=1; after release, a new request completes normally.
